alu_issue: RTL
==============

Name: alu_issue

Overview:
- Drive-side counterpart of COMP_ALU: decodes instruction words into ALU operand/op triples.
- Reads the external register file and applies the same-cycle writeback bypass.
- Tracks pending destination registers in a scoreboard and stalls on hazards.
- Presents opa/opb/op/dst to the execute stage through a one-entry registered valid/ready output stage.

Parameters:
- R0_ZERO, 1, when 1 register 0 always reads 0, is never marked pending, and writes to it are ignored by the scoreboard.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction word valid.
- in_instr  in  32  instruction word.
- in_ready  out  1  instruction accepted when in_valid and in_ready are both high.
- rf_raddr_a  out  4  register file read address A; combinational, equals in_instr[22:19].
- rf_raddr_b  out  4  register file read address B; combinational, equals in_instr[15:12].
- rf_rdata_a  in  32  register file read data A, combinational.
- rf_rdata_b  in  32  register file read data B, combinational.
- wb_en  in  1  writeback strobe from the execute stage.
- wb_addr  in  4  writeback register address.
- wb_data  in  32  writeback data.
- out_valid  out  1  opa/opb/op/dst are valid.
- out_ready  in  1  execute stage accepts the output.
- opa  out  32  signed first ALU operand.
- opb  out  32  signed second ALU operand.
- op  out  4  ALU op code.
- dst  out  4  destination register.
- err  out  1  sticky illegal-op flag.

Behaviour:
- Instruction fields:
  - [31] use_imm
  - [30:27] op
  - [26:23] rd
  - [22:19] ra
  - [18:16] reserved, ignored
  - [15:12] rb
  - [15:0] imm16
- ALU op codes, defined in params.v: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NAND=5, NOR=6, NXOR=7, MVHI=8. Codes 9-15 are illegal.
- Operand A: rf_rdata_a, except wb_data when wb_en and wb_addr==ra (write-first bypass). Forced to 0 when ra==0 and R0_ZERO=1.
- Operand B:
  - use_imm=1: sign-extended imm16, for every op including MVHI.
  - use_imm=0: rf_rdata_b with the same bypass and r0 rule as operand A.
- Scoreboard pend[15:0]:
  - On acceptance of a legal instruction, pend[rd] is set.
  - When wb_en is high, pend[wb_addr] is cleared.
  - Same-cycle set and clear of the same index: set wins.
- Hazard condition, where "clearing" means wb_en && wb_addr==that register this cycle:
  - pend[ra] and not clearing, or
  - !use_imm and pend[rb] and not clearing, or
  - pend[rd] and not clearing (WAW).
- in_ready = (!out_valid || out_ready) && !hazard. Illegal ops ignore the hazard term: in_ready = !out_valid || out_ready.
- Legal accept: the output registers load on the same edge, out_valid=1, so latency is 1 cycle from accept to out_valid.
- Illegal accept:
  - The instruction is consumed and dropped; no output is produced and the scoreboard is unchanged.
  - err is set on that edge and stays set until reset.
  - out_valid=0 after the edge if out_ready was high (or out_valid was already 0); otherwise it holds.
- Output stage:
  - out_valid && out_ready with no new legal accept: out_valid falls on the next edge.
  - Accept and drain in the same cycle gives back-to-back issue with no bubble.
  - opa/opb/op/dst hold stable while out_valid && !out_ready.
- Reset (asynchronous, any time, including mid-stall): out_valid=0, opa=0, opb=0, op=0, dst=0, pend=0, err=0. in_ready is combinational and goes high after reset unless a hazard applies; with pend=0 no hazard applies.
- in_instr is sampled only on accept. Bits [18:16] never affect any output.

Test Plan:
- Reset, then instr use_imm=1, op=ADD, rd=1, ra=0, imm16=0xFFFE -> next cycle out_valid=1, opa=0, opb=0xFFFFFFFE, op=0, dst=1, pend[1]=1.
- Hazard: then instr SUB rd=2, ra=1, rb=3 with no writeback -> in_ready=0. Drive wb_en=1, wb_addr=1, wb_data=0x12345678 -> in_ready=1 the same cycle, and the captured opa=0x12345678.
- Back-to-back: out_ready=1 held, three independent legal instrs on consecutive cycles -> three consecutive out_valid cycles with no bubble, in issue order.
- Backpressure: out_ready=0 with a valid output -> opa/opb/op/dst hold, in_ready=0. Raise out_ready -> the next instr loads on that edge.
- Illegal op=0xB -> accepted, err=1 from the next cycle, no out_valid pulse, pend unchanged. A following legal instr issues normally while err stays 1.
- Assert rst_n=0 mid-stall with pend[5]=1 and out_valid=1 -> all outputs 0 immediately. After release, an instr with ra=5 issues without a stall.

Source files
------------

// File: rtl/alu_issue.sv
// Issue stage: decodes instruction words into ALU operand/op triples, applies the
// writeback bypass, tracks pending destinations and hands off through a one-entry output register.
module alu_issue #(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        in_instr,
  output logic               in_ready,
  output logic [3:0]         rf_raddr_a,
  output logic [3:0]         rf_raddr_b,
  input  logic [31:0]        rf_rdata_a,
  input  logic [31:0]        rf_rdata_b,
  input  logic               wb_en,
  input  logic [3:0]         wb_addr,
  input  logic [31:0]        wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] opa,
  output logic signed [31:0] opb,
  output logic [3:0]         op,
  output logic [3:0]         dst,
  output logic               err
);

  localparam int DATA_W = 32;
  localparam logic [3:0] OP_MVHI = 4'd8;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] read_reg(
    input logic [3:0]        addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              byp_en,
    input logic [3:0]        byp_addr,
    input logic [DATA_W-1:0] byp_data
  );
    if (R0_ZERO && addr == 4'd0) return '0;
    if (byp_en && byp_addr == addr) return byp_data;
    return rf_data;
  endfunction

  // Stage p0: combinational decode, operand fetch and hazard check
  logic                     use_imm_p0;
  logic [3:0]               op_p0, rd_p0, ra_p0, rb_p0;
  logic [15:0]              imm_p0;
  logic                     legal_p0, hazard_p0, accept_p0, issue_p0;
  logic signed [DATA_W-1:0] opa_p0, opb_p0;
  logic [15:0]              pend, pend_nxt;
  logic                     unused_rsvd;

  assign use_imm_p0  = in_instr[31];
  assign op_p0       = in_instr[30:27];
  assign rd_p0       = in_instr[26:23];
  assign ra_p0       = in_instr[22:19];
  assign rb_p0       = in_instr[15:12];
  assign imm_p0      = in_instr[15:0];
  assign unused_rsvd = ^in_instr[18:16];

  assign rf_raddr_a = ra_p0;
  assign rf_raddr_b = rb_p0;

  assign legal_p0 = (op_p0 <= OP_MVHI);

  assign opa_p0 = read_reg(ra_p0, rf_rdata_a, wb_en, wb_addr, wb_data);
  assign opb_p0 = use_imm_p0 ? sext16(imm_p0)
                             : read_reg(rb_p0, rf_rdata_b, wb_en, wb_addr, wb_data);

  // A pending register whose writeback lands this cycle no longer blocks issue
  assign hazard_p0 = (pend[ra_p0] && !(wb_en && wb_addr == ra_p0))
                  || (!use_imm_p0 && pend[rb_p0] && !(wb_en && wb_addr == rb_p0))
                  || (pend[rd_p0] && !(wb_en && wb_addr == rd_p0));

  assign in_ready  = (!out_valid || out_ready) && (!hazard_p0 || !legal_p0);
  assign accept_p0 = in_valid && in_ready;
  assign issue_p0  = accept_p0 && legal_p0;

  always_comb begin
    pend_nxt = pend;
    if (wb_en) pend_nxt[wb_addr] = 1'b0;
    if (issue_p0 && !(R0_ZERO && rd_p0 == 4'd0)) pend_nxt[rd_p0] = 1'b1;
  end

  // Stage p1: registered output slot, scoreboard and sticky error
  logic                     vld_p1;
  logic signed [DATA_W-1:0] opa_p1, opb_p1;
  logic [3:0]               op_p1, dst_p1;
  logic                     err_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      opa_p1 <= '0;
      opb_p1 <= '0;
      op_p1  <= '0;
      dst_p1 <= '0;
      pend   <= '0;
      err_p1 <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (accept_p0 && !legal_p0) err_p1 <= 1'b1;
      if (issue_p0) begin
        vld_p1 <= 1'b1;
        opa_p1 <= opa_p0;
        opb_p1 <= opb_p0;
        op_p1  <= op_p0;
        dst_p1 <= rd_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign opa       = opa_p1;
  assign opb       = opb_p1;
  assign op        = op_p1;
  assign dst       = dst_p1;
  assign err       = err_p1;

endmodule
